// File: rtl/occupied_width_table.sv
// Per-ID occupied-width table: allocate/release writes, NUM_RD write-first read ports,
// swept clear and sticky error flags. Build option: OWT_SATURATE_EN (clamp instead of wrap).
module occupied_width_table #(
    parameter int NUM_IDS  = 14,
    parameter int ID_W     = 4,
    parameter int WIDTH_W  = 7,
    parameter int AMT_W    = 5,
    parameter int NUM_RD   = 3,
    parameter int CAPACITY = 127
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_op,
    input  logic [ID_W-1:0]           wr_id,
    input  logic [AMT_W-1:0]          wr_amt,
    input  logic                      rd_valid,
    input  logic [NUM_RD*ID_W-1:0]    rd_id,
    output logic [NUM_RD*WIDTH_W-1:0] rd_width,
    output logic                      rd_ovalid,
    input  logic                      clr_req,
    output logic                      busy,
    output logic                      err_ovf,
    output logic                      err_udf,
    output logic                      err_id,
    input  logic                      err_clr
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam logic [WIDTH_W-1:0] CAP_VAL  = WIDTH_W'(CAPACITY);
    localparam logic [WIDTH_W:0]   CAP_EXT  = (WIDTH_W+1)'(CAPACITY);
    localparam logic [ID_W:0]      ID_LIMIT = (ID_W+1)'(NUM_IDS);
    localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NUM_IDS - 1);
    localparam logic [ID_W-1:0]    FIRST_ID = ID_W'(1);
    localparam logic [WIDTH_W-1:0] ZERO_W   = {WIDTH_W{1'b0}};

    state_t                    state_r, state_next_s;
    logic [ID_W-1:0]           ptr_r;
    logic                      busy_r, wr_ready_r;
    logic [WIDTH_W-1:0]        table_r [NUM_IDS];
    logic                      clr_now_s;
    logic                      wr_fire_s, wr_legal_s;
    logic [WIDTH_W-1:0]        wr_cur_s, wr_new_s;
    logic [WIDTH_W:0]          wr_ext_s, wr_res_s;
    logic                      ovf_s, udf_s;
    logic [NUM_RD*WIDTH_W-1:0] rd_val_s, rd_width_r;
    logic                      rd_bad_s, rd_ovalid_r;
    logic                      err_ovf_r, err_udf_r, err_id_r;
    logic                      set_ovf_s, set_udf_s, set_id_s;

    function automatic logic id_exists(input logic [ID_W-1:0] id);
        return ({1'b0, id} < ID_LIMIT);
    endfunction

    // ID 0 is reserved: it reads as CAPACITY and can never be written
    function automatic logic id_writable(input logic [ID_W-1:0] id);
        return (id != {ID_W{1'b0}}) && id_exists(id);
    endfunction

    assign wr_fire_s  = wr_valid & wr_ready_r & en;
    assign wr_legal_s = id_writable(wr_id);
    assign wr_ext_s   = {{(WIDTH_W+1-AMT_W){1'b0}}, wr_amt};

    // Clear-sweep FSM next state; clr_now_s marks the cycle an entry is zeroed
    always_comb begin
        state_next_s = state_r;
        clr_now_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && clr_req) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (en) begin
                    clr_now_s = 1'b1;
                    if (ptr_r == LAST_ID) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_CLEAR;
                    end
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, sweep pointer and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= FIRST_ID;
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b1;
        end else if (en) begin
            state_r    <= state_next_s;
            busy_r     <= (state_next_s == ST_CLEAR);
            wr_ready_r <= (state_next_s != ST_CLEAR);
            if (state_r == ST_IDLE) begin
                ptr_r <= FIRST_ID;
            end else begin
                ptr_r <= ptr_r + ID_W'(1);
            end
        end
    end

    // Add/subtract one bit wider than the entry so the carry/borrow exposes over/underflow
    always_comb begin
        wr_cur_s = ZERO_W;
        if (wr_legal_s) begin
            wr_cur_s = table_r[wr_id];
        end else begin
            wr_cur_s = ZERO_W;
        end
        if (wr_op == 1'b0) begin
            wr_res_s = {1'b0, wr_cur_s} + wr_ext_s;
            ovf_s    = (wr_res_s > CAP_EXT);
            udf_s    = 1'b0;
        end else begin
            wr_res_s = {1'b0, wr_cur_s} - wr_ext_s;
            ovf_s    = 1'b0;
            udf_s    = wr_res_s[WIDTH_W];
        end
`ifdef OWT_SATURATE_EN
        if (ovf_s) begin
            wr_new_s = CAP_VAL;
        end else if (udf_s) begin
            wr_new_s = ZERO_W;
        end else begin
            wr_new_s = wr_res_s[WIDTH_W-1:0];
        end
`else
        wr_new_s = wr_res_s[WIDTH_W-1:0];
`endif
    end

    // Per-port read value with write-first forwarding and sweep bypass
    always_comb begin
        rd_val_s = {(NUM_RD*WIDTH_W){1'b0}};
        rd_bad_s = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_id[k*ID_W +: ID_W] == {ID_W{1'b0}}) begin
                rd_val_s[k*WIDTH_W +: WIDTH_W] = CAP_VAL;
            end else if (!id_exists(rd_id[k*ID_W +: ID_W])) begin
                rd_val_s[k*WIDTH_W +: WIDTH_W] = ZERO_W;
                rd_bad_s = 1'b1;
            end else if (wr_fire_s && wr_legal_s && (wr_id == rd_id[k*ID_W +: ID_W])) begin
                rd_val_s[k*WIDTH_W +: WIDTH_W] = wr_new_s;
            end else if (clr_now_s && (ptr_r == rd_id[k*ID_W +: ID_W])) begin
                rd_val_s[k*WIDTH_W +: WIDTH_W] = ZERO_W;
            end else begin
                rd_val_s[k*WIDTH_W +: WIDTH_W] = table_r[rd_id[k*ID_W +: ID_W]];
            end
        end
    end

    // Table storage: sweep and writes never coincide because writes stall during CLEAR
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                table_r[i] <= ZERO_W;
            end
        end else if (clr_now_s) begin
            table_r[ptr_r] <= ZERO_W;
        end else if (wr_fire_s && wr_legal_s) begin
            table_r[wr_id] <= wr_new_s;
        end
    end

    // Read output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_width_r  <= {(NUM_RD*WIDTH_W){1'b0}};
            rd_ovalid_r <= 1'b0;
        end else if (en) begin
            if (rd_valid) begin
                rd_width_r  <= rd_val_s;
                rd_ovalid_r <= 1'b1;
            end else begin
                rd_ovalid_r <= 1'b0;
            end
        end
    end

    assign set_ovf_s = wr_fire_s & wr_legal_s & ovf_s;
    assign set_udf_s = wr_fire_s & wr_legal_s & udf_s;
    assign set_id_s  = (wr_fire_s & ~wr_legal_s) | (en & rd_valid & rd_bad_s);

    // Sticky error flags; a new error outranks err_clr in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_r <= 1'b0;
            err_udf_r <= 1'b0;
            err_id_r  <= 1'b0;
        end else if (en) begin
            err_ovf_r <= set_ovf_s | (err_ovf_r & ~err_clr);
            err_udf_r <= set_udf_s | (err_udf_r & ~err_clr);
            err_id_r  <= set_id_s  | (err_id_r  & ~err_clr);
        end
    end

    assign wr_ready  = wr_ready_r;
    assign busy      = busy_r;
    assign rd_width  = rd_width_r;
    assign rd_ovalid = rd_ovalid_r;
    assign err_ovf   = err_ovf_r;
    assign err_udf   = err_udf_r;
    assign err_id    = err_id_r;
endmodule

// File: tb/tb_occupied_width_table.sv
// Self-checking bench for occupied_width_table: directed scenarios plus randomized traffic
// compared every cycle against an integer-arithmetic reference model.
module tb_occupied_width_table;
    localparam int NUM_IDS  = 14;
    localparam int ID_W     = 4;
    localparam int WIDTH_W  = 7;
    localparam int AMT_W    = 5;
    localparam int NUM_RD   = 3;
    localparam int CAPACITY = 127;

    logic                      clk = 1'b0;
    logic                      rst, en, wr_valid, wr_ready, wr_op, rd_valid, rd_ovalid;
    logic [ID_W-1:0]           wr_id;
    logic [AMT_W-1:0]          wr_amt;
    logic [NUM_RD*ID_W-1:0]    rd_id;
    logic [NUM_RD*WIDTH_W-1:0] rd_width;
    logic                      clr_req, busy, err_ovf, err_udf, err_id, err_clr;

    always #5 clk = ~clk;

    occupied_width_table #(
        .NUM_IDS(NUM_IDS), .ID_W(ID_W), .WIDTH_W(WIDTH_W),
        .AMT_W(AMT_W), .NUM_RD(NUM_RD), .CAPACITY(CAPACITY)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_op(wr_op), .wr_id(wr_id), .wr_amt(wr_amt), .rd_valid(rd_valid),
        .rd_id(rd_id), .rd_width(rd_width), .rd_ovalid(rd_ovalid), .clr_req(clr_req),
        .busy(busy), .err_ovf(err_ovf), .err_udf(err_udf), .err_id(err_id),
        .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int r_ids [NUM_RD];

    // Reference model state: table contents, sweep progress, expected registered outputs
    int m_tbl [NUM_IDS];
    bit m_busy;
    int m_ptr;
    int m_rdw [NUM_RD];
    bit m_rdv, m_ovf, m_udf, m_idf;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int port_w(input int k);
        return int'(rd_width[k*WIDTH_W +: WIDTH_W]);
    endfunction

    // One clock of the behavioural model, evaluated from the inputs about to be sampled
    task automatic model_update();
        int nv [NUM_IDS];
        int r, wid, id;
        bit so, su, si;
        so = 1'b0; su = 1'b0; si = 1'b0;
        if (rst) begin
            foreach (m_tbl[i]) m_tbl[i] = 0;
            foreach (m_rdw[i]) m_rdw[i] = 0;
            m_busy = 1'b0; m_ptr = 0; m_rdv = 1'b0;
            m_ovf = 1'b0; m_udf = 1'b0; m_idf = 1'b0;
            return;
        end
        if (!en) return;
        nv = m_tbl;
        wid = int'(wr_id);
        if (wr_valid && !m_busy) begin
            if (wid == 0 || wid >= NUM_IDS) begin
                si = 1'b1;
            end else begin
                r = wr_op ? m_tbl[wid] - int'(wr_amt) : m_tbl[wid] + int'(wr_amt);
                if (r > CAPACITY) so = 1'b1;
                if (r < 0) su = 1'b1;
`ifdef OWT_SATURATE_EN
                if (r > CAPACITY) r = CAPACITY;
                if (r < 0) r = 0;
`else
                r = (r + 2 * (1 << WIDTH_W)) % (1 << WIDTH_W);
`endif
                nv[wid] = r;
            end
        end
        if (m_busy) nv[m_ptr] = 0;
        if (rd_valid) begin
            for (int k = 0; k < NUM_RD; k++) begin
                id = r_ids[k];
                if (id == 0) m_rdw[k] = CAPACITY;
                else if (id >= NUM_IDS) begin
                    m_rdw[k] = 0;
                    si = 1'b1;
                end else m_rdw[k] = nv[id];
            end
            m_rdv = 1'b1;
        end else begin
            m_rdv = 1'b0;
        end
        if (m_busy) begin
            if (m_ptr == NUM_IDS - 1) m_busy = 1'b0;
            else m_ptr++;
        end else if (clr_req) begin
            m_busy = 1'b1;
            m_ptr  = 1;
        end
        m_ovf = so | (m_ovf & !err_clr);
        m_udf = su | (m_udf & !err_clr);
        m_idf = si | (m_idf & !err_clr);
        m_tbl = nv;
    endtask

    task automatic compare_all();
        check_value("rd_ovalid", int'(rd_ovalid), int'(m_rdv));
        for (int k = 0; k < NUM_RD; k++) begin
            check_value($sformatf("rd_width%0d", k), port_w(k), m_rdw[k]);
        end
        check_value("busy", int'(busy), int'(m_busy));
        check_value("wr_ready", int'(wr_ready), int'(!m_busy));
        check_value("err_ovf", int'(err_ovf), int'(m_ovf));
        check_value("err_udf", int'(err_udf), int'(m_udf));
        check_value("err_id", int'(err_id), int'(m_idf));
    endtask

    task automatic step();
        rd_id = {ID_W'(r_ids[2]), ID_W'(r_ids[1]), ID_W'(r_ids[0])};
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst = 1'b0; en = 1'b1; wr_valid = 1'b0; wr_op = 1'b0;
        wr_id = '0; wr_amt = '0; rd_valid = 1'b0;
        clr_req = 1'b0; err_clr = 1'b0;
        foreach (r_ids[k]) r_ids[k] = 0;
    endtask

    task automatic do_write(input bit op, input int id, input int amt);
        wr_valid = 1'b1; wr_op = op; wr_id = ID_W'(id); wr_amt = AMT_W'(amt);
        step();
        idle();
    endtask

    task automatic do_read(input int a, input int b, input int c);
        rd_valid = 1'b1;
        r_ids[0] = a; r_ids[1] = b; r_ids[2] = c;
        step();
        idle();
    endtask

    initial begin
        int cnt;
        idle();
        rst = 1'b1;
        step();
        idle();

        // Reset values then the reserved/empty reads
        do_read(0, 1, 13);
        check_value("t1_port0", port_w(0), 127);
        check_value("t1_port1", port_w(1), 0);
        check_value("t1_port2", port_w(2), 0);
        check_value("t1_ovalid", int'(rd_ovalid), 1);

        // Allocate then release
        do_write(1'b0, 5, 16);
        do_write(1'b0, 5, 16);
        do_write(1'b0, 5, 4);
        do_read(5, 5, 5);
        check_value("t2_alloc", port_w(0), 36);
        do_write(1'b1, 5, 6);
        do_read(5, 0, 5);
        check_value("t2_release", port_w(2), 30);

        // Same-cycle write and read of one id
        do_write(1'b0, 3, 10);
        wr_valid = 1'b1; wr_op = 1'b0; wr_id = 4'd3; wr_amt = 5'd16;
        rd_valid = 1'b1; r_ids[1] = 3;
        step();
        idle();
        check_value("t3_forward", port_w(1), 26);

        // Overflow, underflow, flag clear
        do_write(1'b0, 7, 31);
        do_write(1'b0, 7, 31);
        do_write(1'b0, 7, 31);
        do_write(1'b0, 7, 27);
        do_write(1'b0, 7, 16);
        check_value("t4_ovf", int'(err_ovf), 1);
        do_read(7, 1, 2);
`ifdef OWT_SATURATE_EN
        check_value("t4_ovf_value", port_w(0), 127);
`else
        check_value("t4_ovf_value", port_w(0), 8);
`endif
        do_write(1'b0, 8, 8);
        do_write(1'b1, 8, 9);
        check_value("t4_udf", int'(err_udf), 1);
        err_clr = 1'b1;
        step();
        idle();
        check_value("t4_clr_ovf", int'(err_ovf), 0);
        check_value("t4_clr_udf", int'(err_udf), 0);

        // Fill every id, sweep, and confirm writes stall while busy
        for (int i = 1; i < NUM_IDS; i++) do_write(1'b0, i, $urandom_range(1, 31));
        clr_req = 1'b1;
        step();
        idle();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) begin
                cnt++;
                check_value("t5_wr_ready", int'(wr_ready), 0);
                wr_valid = 1'b1; wr_id = 4'd4; wr_amt = 5'd9;
            end else begin
                wr_valid = 1'b0;
            end
            step();
        end
        idle();
        check_value("t5_busy_cycles", cnt, 13);
        for (int i = 1; i < NUM_IDS; i += 3) begin
            do_read(i, (i + 1 < NUM_IDS) ? i + 1 : 0, (i + 2 < NUM_IDS) ? i + 2 : 0);
            check_value("t5_cleared", port_w(0) + port_w(1) + port_w(2) -
                        ((i + 1 < NUM_IDS) ? 0 : 127) - ((i + 2 < NUM_IDS) ? 0 : 127), 0);
        end
        do_read(0, 0, 0);
        check_value("t5_id0", port_w(0), 127);

        // Illegal accesses and reset during a sweep
        do_write(1'b0, 2, 5);
        do_write(1'b0, 0, 5);
        check_value("t6_err_id_wr", int'(err_id), 1);
        do_read(2, 0, 1);
        check_value("t6_unchanged", port_w(0), 5);
        err_clr = 1'b1;
        step();
        idle();
        check_value("t6_err_id_clr", int'(err_id), 0);
        do_read(14, 0, 2);
        check_value("t6_id14", port_w(0), 0);
        check_value("t6_err_id_rd", int'(err_id), 1);
        clr_req = 1'b1;
        step();
        idle();
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        idle();
        check_value("t6_rst_busy", int'(busy), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            en       = ($urandom_range(0, 9) != 0);
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_op    = ($urandom_range(0, 2) == 0);
            wr_id    = ID_W'($urandom_range(0, 15));
            wr_amt   = AMT_W'($urandom_range(0, 31));
            rd_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NUM_RD; k++) r_ids[k] = $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) r_ids[1] = int'(wr_id);
            clr_req  = ($urandom_range(0, 59) == 0);
            err_clr  = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
